// File: rtl/rob_pkg.sv
// Shared definitions for the banked reorder-buffer field storage:
// default geometry, index typedefs and the clear-sweep state encoding.
package rob_pkg;

  localparam int ROB_NBANKS = 4;
  localparam int ROB_DEPTH  = 128;

  typedef logic [$clog2(ROB_NBANKS)-1:0] rob_bank_t;
  typedef logic [$clog2(ROB_DEPTH)-1:0]  rob_idx_t;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rob_state_t;

  // A single bank still needs a one-bit select so port widths never collapse to zero.
  function automatic int rob_bank_bits(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

endpackage

// File: rtl/rob_bank_mem.sv
// One bank of ROB field storage: NWR write ports (already decoded to this
// bank by the caller), NRD asynchronous read taps and a sweep write port that
// overrides user writes while the array is being cleared.
module rob_bank_mem
  import rob_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = ROB_DEPTH,
  parameter int               NWR      = 4,
  parameter int               NRD      = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              IW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 sweep,
  input  logic [IW-1:0]        sweep_idx,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*IW-1:0]    widx,
  input  logic [NWR*WIDTH-1:0] wdata,
  input  logic [NRD*IW-1:0]    ridx,
  output logic [NRD*WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Sweep row write, otherwise user writes in port order so the highest port lands last.
  always_ff @(posedge clk) begin
    if (sweep) begin
      mem[sweep_idx] <= INIT_VAL;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wen[p]) begin
          mem[widx[p*IW +: IW]] <= wdata[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Unregistered read taps; the top adds bypass and the output register.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      rdata[i*WIDTH +: WIDTH] = mem[ridx[i*IW +: IW]];
    end
  end

endmodule

// File: rtl/rob_field_bank_ram.sv
// Banked storage for one reorder-buffer field. Several rename/writeback ports
// write and several commit/issue ports read with a one-cycle registered,
// write-first result. A sweep FSM clears every row after reset and on flush.
module rob_field_bank_ram
  import rob_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               NBANKS   = ROB_NBANKS,
  parameter int               DEPTH    = ROB_DEPTH,
  parameter int               NWR      = 4,
  parameter int               NRD      = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              BW       = rob_bank_bits(NBANKS),
  localparam int              IW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*BW-1:0]    wbank,
  input  logic [NWR*IW-1:0]    widx,
  input  logic [NWR*WIDTH-1:0] wdata,
  input  logic [NRD-1:0]       ren,
  input  logic [NRD*BW-1:0]    rbank,
  input  logic [NRD*IW-1:0]    ridx,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rvalid,
  output logic                 busy
);

  rob_state_t     state;
  logic [IW-1:0]  counter;
  logic           idle;
  logic           sweep;
  logic [NWR-1:0] wr_act;
  logic [NRD-1:0] rd_act;

  logic [NBANKS*NRD*WIDTH-1:0] bank_rd;
  logic [WIDTH-1:0]            rd_next [NRD];

  // User traffic only counts once the array is fully cleared.
  assign idle   = (state == IDLE);
  assign sweep  = ~idle;
  assign wr_act = wen & {NWR{idle}};
  assign rd_act = ren & {NRD{idle}};
  assign busy   = (state == CLEAR);

  // Sweep FSM: walk every row once, restarting from row 0 whenever flush arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      counter <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (flush) begin
            counter <= '0;
          end else if (counter == IW'(DEPTH - 1)) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        IDLE: begin
          if (flush) begin
            state   <= CLEAR;
            counter <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          counter <= '0;
        end
      endcase
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [NWR-1:0] sel_wen;

    // Route each active write port to the bank it selects.
    always_comb begin
      sel_wen = '0;
      for (int p = 0; p < NWR; p++) begin
        sel_wen[p] = wr_act[p] && (wbank[p*BW +: BW] == BW'(b));
      end
    end

    rob_bank_mem #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .NWR      (NWR),
      .NRD      (NRD),
      .INIT_VAL (INIT_VAL)
    ) u_mem (
      .clk       (clk),
      .sweep     (sweep),
      .sweep_idx (counter),
      .wen       (sel_wen),
      .widx      (widx),
      .wdata     (wdata),
      .ridx      (ridx),
      .rdata     (bank_rd[b*NRD*WIDTH +: NRD*WIDTH])
    );
  end

  // Pick the addressed bank per read port, then let a same-cycle write override it (highest port last).
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_next[i] = '0;
      for (int b = 0; b < NBANKS; b++) begin
        if (rbank[i*BW +: BW] == BW'(b)) begin
          rd_next[i] = bank_rd[(b*NRD + i)*WIDTH +: WIDTH];
        end
      end
      for (int p = 0; p < NWR; p++) begin
        if (wr_act[p] &&
            (wbank[p*BW +: BW] == rbank[i*BW +: BW]) &&
            (widx[p*IW +: IW] == ridx[i*IW +: IW])) begin
          rd_next[i] = wdata[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Read result register; idle ports return zero so consumers never see stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        rvalid[i]               <= rd_act[i];
        rdata[i*WIDTH +: WIDTH] <= rd_act[i] ? rd_next[i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rob_field_bank_ram.sv
// Directed bench for rob_field_bank_ram: default geometry instance plus a
// small single-bank variant, each scenario checked inline.
module tb_rob_field_bank_ram;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [3:0]   wen;
  logic [7:0]   wbank;
  logic [27:0]  widx;
  logic [127:0] wdata;
  logic [3:0]   ren;
  logic [7:0]   rbank;
  logic [27:0]  ridx;
  logic [127:0] rdata;
  logic [3:0]   rvalid;
  logic         busy;

  logic         v_rst;
  logic         v_flush;
  logic [1:0]   v_wen;
  logic [1:0]   v_wbank;
  logic [7:0]   v_widx;
  logic [13:0]  v_wdata;
  logic [0:0]   v_ren;
  logic [0:0]   v_rbank;
  logic [3:0]   v_ridx;
  logic [6:0]   v_rdata;
  logic [0:0]   v_rvalid;
  logic         v_busy;

  int n_checks = 0;
  int n_fail   = 0;

  rob_field_bank_ram dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wen(wen), .wbank(wbank), .widx(widx), .wdata(wdata),
    .ren(ren), .rbank(rbank), .ridx(ridx),
    .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  rob_field_bank_ram #(
    .WIDTH(7), .NBANKS(1), .DEPTH(16), .NWR(2), .NRD(1)
  ) dut_v (
    .clk(clk), .rst(v_rst), .flush(v_flush),
    .wen(v_wen), .wbank(v_wbank), .widx(v_widx), .wdata(v_wdata),
    .ren(v_ren), .rbank(v_rbank), .ridx(v_ridx),
    .rdata(v_rdata), .rvalid(v_rvalid), .busy(v_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    wen   = '0;
    ren   = '0;
    flush = 1'b0;
  endtask

  task automatic set_write(input int p, input logic [1:0] b, input logic [6:0] i,
                           input logic [31:0] d);
    wen[p]           = 1'b1;
    wbank[p*2 +: 2]  = b;
    widx[p*7 +: 7]   = i;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic set_read(input int p, input logic [1:0] b, input logic [6:0] i);
    ren[p]          = 1'b1;
    rbank[p*2 +: 2] = b;
    ridx[p*7 +: 7]  = i;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int cnt;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 1", busy); end
    n_checks++;
    if (rvalid !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_rvalid got %b want 0000", rvalid); end
    n_checks++;
    if (rdata !== 128'd0) begin n_fail++; $display("[TB] FAIL reset_rdata got %h want 0", rdata); end
    n_checks++;
    if (v_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_v_busy got %b want 1", v_busy); end
    rst = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 128) begin n_fail++; $display("[TB] FAIL reset_sweep_len got %0d want 128", cnt); end
    set_read(0, 2'd2, 7'd77);
    @(negedge clk);
    idle_inputs();
    d = rdata[31:0];
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL cleared_read got %h want 0", d); end
    n_checks++;
    if (rvalid !== 4'b0001) begin n_fail++; $display("[TB] FAIL cleared_rvalid got %b want 0001", rvalid); end
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    set_write(0, 2'd1, 7'd5, 32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    set_read(3, 2'd1, 7'd5);
    @(negedge clk);
    idle_inputs();
    d = rdata[127:96];
    n_checks++;
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL wr_rd_data got %h want deadbeef", d); end
    n_checks++;
    if (rvalid !== 4'b1000) begin n_fail++; $display("[TB] FAIL wr_rd_rvalid got %b want 1000", rvalid); end
    @(negedge clk);
    n_checks++;
    if (rvalid !== 4'b0000 || rdata !== 128'd0) begin
      n_fail++; $display("[TB] FAIL no_read_zero got rvalid=%b rdata=%h want 0", rvalid, rdata);
    end
  endtask

  task automatic test_priority_bypass();
    logic [31:0] d;
    set_write(0, 2'd0, 7'd9, 32'h11);
    set_write(2, 2'd0, 7'd9, 32'h22);
    set_read(0, 2'd0, 7'd9);
    @(negedge clk);
    idle_inputs();
    d = rdata[31:0];
    n_checks++;
    if (d !== 32'h22) begin n_fail++; $display("[TB] FAIL prio_bypass got %h want 22", d); end
    set_read(0, 2'd0, 7'd9);
    @(negedge clk);
    idle_inputs();
    d = rdata[31:0];
    n_checks++;
    if (d !== 32'h22) begin n_fail++; $display("[TB] FAIL prio_stored got %h want 22", d); end
    set_write(1, 2'd2, 7'd3, 32'h33);
    set_write(3, 2'd2, 7'd4, 32'h44);
    set_read(1, 2'd2, 7'd3);
    set_read(2, 2'd2, 7'd4);
    @(negedge clk);
    idle_inputs();
    d = rdata[63:32];
    n_checks++;
    if (d !== 32'h33) begin n_fail++; $display("[TB] FAIL bypass_addr_p1 got %h want 33", d); end
    d = rdata[95:64];
    n_checks++;
    if (d !== 32'h44) begin n_fail++; $display("[TB] FAIL bypass_addr_p2 got %h want 44", d); end
  endtask

  task automatic test_multi_read();
    set_read(0, 2'd1, 7'd5);
    set_read(1, 2'd1, 7'd5);
    set_read(2, 2'd0, 7'd9);
    set_read(3, 2'd1, 7'd5);
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (rdata !== {32'hDEADBEEF, 32'h22, 32'hDEADBEEF, 32'hDEADBEEF}) begin
      n_fail++; $display("[TB] FAIL multi_read got %h want deadbeef_00000022_deadbeef_deadbeef", rdata);
    end
    n_checks++;
    if (rvalid !== 4'b1111) begin n_fail++; $display("[TB] FAIL multi_rvalid got %b want 1111", rvalid); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int cnt;
    bit rv_bad;
    set_write(1, 2'd3, 7'd127, 32'hA5);
    @(negedge clk);
    idle_inputs();
    flush = 1'b1;
    set_read(1, 2'd3, 7'd127);
    @(negedge clk);
    flush = 1'b0;
    d = rdata[63:32];
    n_checks++;
    if (d !== 32'hA5 || rvalid[1] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL flush_cycle_read got %h/%b want a5/1", d, rvalid[1]);
    end
    cnt = 1;
    rv_bad = 1'b0;
    @(negedge clk);
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      if (rvalid !== 4'b0000) rv_bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 128) begin n_fail++; $display("[TB] FAIL flush_sweep_len got %0d want 128", cnt); end
    n_checks++;
    if (rv_bad || rvalid !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL flush_rvalid_during_sweep got %b want 0000", rvalid);
    end
    @(negedge clk);
    idle_inputs();
    d = rdata[63:32];
    n_checks++;
    if (d !== 32'd0 || rvalid[1] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL flush_cleared got %h/%b want 0/1", d, rvalid[1]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    bit rv_bad;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    set_read(0, 2'd0, 7'd9);
    repeat (60) @(negedge clk);
    rst = 1'b0;
    rv_bad = 1'b0;
    #1;
    if (busy !== 1'b1 || rvalid !== 4'b0000) rv_bad = 1'b1;
    @(negedge clk);
    if (busy !== 1'b1 || rvalid !== 4'b0000) rv_bad = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rv_bad || busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midsweep_reset_hold got busy=%b rvalid=%b want 1/0000", busy, rvalid);
    end
    rst = 1'b1;
    cnt = 0;
    rv_bad = 1'b0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      if (rvalid !== 4'b0000) rv_bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 128) begin n_fail++; $display("[TB] FAIL midsweep_restart_len got %0d want 128", cnt); end
    n_checks++;
    if (rv_bad) begin n_fail++; $display("[TB] FAIL midsweep_rvalid got 1 want 0"); end
    @(negedge clk);
    n_checks++;
    if (rvalid !== 4'b0001) begin n_fail++; $display("[TB] FAIL post_sweep_read got %b want 0001", rvalid); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (rvalid !== 4'b0000 || rdata !== 128'd0) begin
      n_fail++; $display("[TB] FAIL async_drop got rvalid=%b rdata=%h want 0", rvalid, rdata);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 128) begin n_fail++; $display("[TB] FAIL reset_again_len got %0d want 128", cnt); end
  endtask

  task automatic test_variant();
    int cnt;
    v_rst = 1'b1;
    cnt = 0;
    while (v_busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 16) begin n_fail++; $display("[TB] FAIL variant_sweep_len got %0d want 16", cnt); end
    v_wen   = 2'b10;
    v_wbank = 2'b00;
    v_widx  = {4'd15, 4'd0};
    v_wdata = {7'h7F, 7'h00};
    @(negedge clk);
    v_wen  = 2'b00;
    v_ren  = 1'b1;
    v_rbank = 1'b0;
    v_ridx = 4'd15;
    @(negedge clk);
    v_ren = 1'b0;
    n_checks++;
    if (v_rdata !== 7'h7F || v_rvalid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL variant_roundtrip got %h/%b want 7f/1", v_rdata, v_rvalid);
    end
    v_wen   = 2'b11;
    v_widx  = {4'd3, 4'd3};
    v_wdata = {7'h34, 7'h12};
    @(negedge clk);
    v_wen  = 2'b00;
    v_ren  = 1'b1;
    v_ridx = 4'd3;
    @(negedge clk);
    v_ren = 1'b0;
    n_checks++;
    if (v_rdata !== 7'h34) begin n_fail++; $display("[TB] FAIL variant_prio got %h want 34", v_rdata); end
  endtask

  initial begin
    rst     = 1'b1;
    v_rst   = 1'b1;
    flush   = 1'b0;
    wen     = '0;
    wbank   = '0;
    widx    = '0;
    wdata   = '0;
    ren     = '0;
    rbank   = '0;
    ridx    = '0;
    v_flush = 1'b0;
    v_wen   = '0;
    v_wbank = '0;
    v_widx  = '0;
    v_wdata = '0;
    v_ren   = '0;
    v_rbank = '0;
    v_ridx  = '0;
    #2;
    rst   = 1'b0;
    v_rst = 1'b0;
    test_reset();
    test_write_read();
    test_priority_bypass();
    test_multi_read();
    test_flush();
    test_reset_mid_sweep();
    test_variant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_field_bank_ram.md
Name: rob_field_bank_ram

Overview:
- Synthesizable, parametrised banked storage for one reorder-buffer field. It replaces the DPI-C backed per-field read/write pair.
- Multiple write ports (rename/dispatch and writeback) and multiple read ports (commit/issue) access NBANKS banks of DEPTH entries each.
- Reads are registered, with write-first bypass.
- Clearing is a hardware sweep state machine, triggered by reset and by flush.
- One instance exists per ROB field inside the ROB top.

Parameters:
- WIDTH, 32, field width in bits.
- NBANKS, 4, number of banks; power of two, at least 1.
- DEPTH, 128, entries per bank; power of two, at least 2.
- NWR, 4, number of write ports.
- NRD, 4, number of read ports.
- INIT_VAL, 0, value written to every entry by the clear sweep.
- BW, derived, clog2(NBANKS), minimum 1.
- IW, derived, clog2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  request a full clear sweep.
- wen  in  NWR  per-port write enable.
- wbank  in  NWR*BW  per-port bank select.
- widx  in  NWR*IW  per-port entry index.
- wdata  in  NWR*WIDTH  per-port write data.
- ren  in  NRD  per-port read enable.
- rbank  in  NRD*BW  per-port bank select.
- ridx  in  NRD*IW  per-port entry index.
- rdata  out  NRD*WIDTH  per-port read data, one cycle after ren.
- rvalid  out  NRD  per-port read-data-valid.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CLEAR, sweep counter=0.
  - busy=1, rvalid=0, rdata=0.
  - Array contents are not reset directly; the sweep clears them.
- States: CLEAR, IDLE.
- CLEAR state:
  - Each cycle, row `counter` is written with INIT_VAL in all banks, then the counter increments.
  - After row DEPTH-1 is written, next state is IDLE and busy falls on the following cycle.
  - The sweep therefore takes exactly DEPTH cycles after rst deasserts.
  - User wen and ren are ignored; rvalid stays 0.
  - flush=1 during CLEAR restarts the counter at 0.
- IDLE state:
  - flush=1 moves to CLEAR with counter=0 on the next edge.
  - Reads and writes issued in the same cycle as flush are still honoured.
- Write:
  - On the clk edge, each port with wen=1 writes wdata to [wbank][widx].
  - Same bank and index on several ports in one cycle: the highest-numbered port wins. No error is flagged.
- Read:
  - ren[i]=1 in cycle t gives rdata[i] and rvalid[i]=1 in cycle t+1.
  - ren[i]=0 gives rdata[i]=0 and rvalid[i]=0 next cycle.
- Bypass:
  - If a write in cycle t hits the same bank and index as read i in cycle t, rdata[i] returns the written value (write-first).
  - The highest-numbered matching write port supplies it.
- Any number of read ports may address the same entry.
- Wrap-around: none. Callers own the ROB head/tail pointers.
- Reset asserted mid-sweep or mid-read restarts CLEAR at row 0 and drops rvalid immediately.

Decomposition:
- Shared package rob_pkg holds:
  - ROB_NBANKS and ROB_DEPTH constants.
  - rob_bank_t and rob_idx_t typedefs.
  - The state enum {CLEAR, IDLE}.
- One sub-module, rob_bank_mem: a single bank with NWR write ports, NRD async read taps and INIT_VAL sweep write, instantiated NBANKS times.
- The top holds the sweep FSM, bank decode, write-priority logic, bypass muxes and read registers.

Test Plan:
1. Release rst at t0 with default parameters:
   - busy=1 for exactly 128 cycles, then busy=0.
   - Reading bank 2, index 77 then returns 0 with rvalid=1.
2. Write 0xDEADBEEF at bank 1, index 5 via port 0. Next cycle, read port 3 at bank 1, index 5:
   - One cycle later rdata[3]=0xDEADBEEF, rvalid[3]=1.
3. In one cycle, port 0 writes 0x11 and port 2 writes 0x22 to bank 0, index 9, while read port 0 reads bank 0, index 9:
   - Next cycle rdata[0]=0x22.
   - A later read also returns 0x22.
4. Fill bank 3, index 127 with 0xA5, then pulse flush:
   - busy=1 for 128 cycles.
   - ren during the sweep gives rvalid=0.
   - After the sweep, the read returns 0.
5. Assert rst=0 at sweep row 60 for 2 cycles:
   - busy stays 1.
   - The sweep restarts at 0 and completes 128 cycles after rst=1.
   - rvalid=0 throughout.
6. Parameter variant NBANKS=1, DEPTH=16, WIDTH=7, NWR=2, NRD=1:
   - Sweep takes 16 cycles.
   - Write and read of 0x7F at index 15 round-trips correctly.
